// File: rtl/divider_controller_if.sv
// divider_controller_if: start/status handshake plus datapath control strobes between controller and datapath
interface divider_controller_if;
   logic start, ready, done, err_dvz, err_ovf;
   logic Cn, ovf, neg, zer;
   logic Qp1, Qsl, Qrd, Asl, Ard, Drd, Crst, Cp1, Anew;
   modport master (
      output start, Cn, ovf, neg, zer,
      input  ready, done, err_dvz, err_ovf, Qp1, Qsl, Qrd, Asl, Ard, Drd, Crst, Cp1, Anew
   );
   modport slave (
      input  start, Cn, ovf, neg, zer,
      output ready, done, err_dvz, err_ovf, Qp1, Qsl, Qrd, Asl, Ard, Drd, Crst, Cp1, Anew
   );
endinterface

// File: rtl/divider_controller.sv
// divider_controller: restoring-division sequencer; define DIVIDER_OVF_CHECK_EN to abort on quotient overflow
module divider_controller #(
   parameter int bitsofn = 3,
   parameter int n       = 5
) (
   input logic              clk,
   input logic              rst_n,
   divider_controller_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOAD, CHECK, SHIFT, SUB, DONE, ERR} state_t;
   state_t state_q, state_d;
   logic   err_dvz_q, err_dvz_d, err_ovf_q, err_ovf_d;
   if (n < 1 || (2 ** bitsofn) <= n) begin : g_param_chk
      $error("divider_controller: bitsofn too narrow to count to n");
   end
`ifndef DIVIDER_OVF_CHECK_EN
   logic unused_ovf;
   assign unused_ovf = bus.ovf;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         err_dvz_q <= 1'b0;
         err_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         err_dvz_q <= err_dvz_d;
         err_ovf_q <= err_ovf_d;
      end
   end
   always_comb begin
      state_d   = state_q;
      err_dvz_d = err_dvz_q;
      err_ovf_d = err_ovf_q;
      case (state_q)
         IDLE: if (bus.start) begin
            state_d   = LOAD;
            err_dvz_d = 1'b0;
            err_ovf_d = 1'b0;
         end
         LOAD: state_d = CHECK;
         CHECK: begin
            // divide-by-zero outranks overflow so at most one error flag is ever set
            if (bus.zer) begin
               state_d   = ERR;
               err_dvz_d = 1'b1;
            end
`ifdef DIVIDER_OVF_CHECK_EN
            else if (bus.ovf) begin
               state_d   = ERR;
               err_ovf_d = 1'b1;
            end
`endif
            else state_d = SHIFT;
         end
         SHIFT: state_d = SUB;
         SUB: state_d = bus.Cn ? DONE : SHIFT;
         DONE, ERR: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   assign bus.ready   = (state_q == IDLE);
   assign bus.done    = (state_q == DONE) || (state_q == ERR);
   assign bus.err_dvz = err_dvz_q;
   assign bus.err_ovf = err_ovf_q;
   assign bus.Anew    = (state_q == LOAD);
   assign bus.Qrd     = (state_q == LOAD);
   assign bus.Drd     = (state_q == LOAD);
   assign bus.Crst    = (state_q == LOAD);
   assign bus.Asl     = (state_q == SHIFT);
   assign bus.Qsl     = (state_q == SHIFT);
   assign bus.Cp1     = (state_q == SHIFT);
   // a negative trial difference restores simply by leaving A unwritten
   assign bus.Qp1     = (state_q == SUB) && !bus.neg;
   assign bus.Ard     = (state_q == LOAD) || ((state_q == SUB) && !bus.neg);
endmodule

// File: tb/tb_divider_controller.sv
// tb_divider_controller: drives the controller with a behavioural restoring datapath, checks results against integer division
module tb_divider_controller;
   localparam int N = 5;
   logic clk = 1'b0;
   logic rst_n;
   logic [2*N-1:0] ain;
   logic [N-1:0] din, q, d;
   logic [N:0] ah;
   int c;
   int cp1_cnt = 0, qp1_cnt = 0, done_cnt = 0;
   int checks = 0, errors = 0;
   divider_controller_if bus ();
   divider_controller #(.bitsofn(3), .n(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   assign bus.zer = (d == '0);
   assign bus.ovf = (ah >= {1'b0, d});
   assign bus.neg = (ah < {1'b0, d});
   assign bus.Cn  = (c == N);
   always @(posedge clk) begin
      if (bus.Ard && bus.Anew) ah <= {1'b0, ain[2*N-1:N]};
      else if (bus.Ard) ah <= ah - {1'b0, d};
      else if (bus.Asl) ah <= {ah[N-1:0], q[N-1]};
      if (bus.Qrd) q <= ain[N-1:0];
      else if (bus.Qsl) q <= q << 1;
      else if (bus.Qp1) q <= q | 1;
      if (bus.Drd) d <= din;
      if (bus.Crst) c <= 0;
      else if (bus.Cp1) c <= c + 1;
   end
   always @(negedge clk) begin
      if (bus.Cp1) cp1_cnt++;
      if (bus.Qp1) qp1_cnt++;
      if (bus.done) done_cnt++;
   end
   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask
   // latency = rising edges from the accepting edge (inclusive) to the edge that raises done
   task automatic run_op(input logic [2*N-1:0] a, input logic [N-1:0] dv, input bit repulse);
      int lat, cp0, qp0, dn0;
      bit dvz, big, eovf;
      dvz = (dv == 0);
      big = !dvz && ((int'(a) / int'(dv)) >= (1 << N));
`ifdef DIVIDER_OVF_CHECK_EN
      eovf = big;
`else
      eovf = 1'b0;
`endif
      ain = a;
      din = dv;
      bus.start = 1'b1;
      cp0 = cp1_cnt;
      qp0 = qp1_cnt;
      dn0 = done_cnt;
      chk("ready_idle", bus.ready, 1);
      @(posedge clk);
      #1 bus.start = 1'b0;
      lat = 1;
      while (!bus.done && lat < 64) begin
         bus.start = repulse && (lat == 4);
         @(posedge clk);
         #1 lat++;
      end
      bus.start = 1'b0;
      chk("done", bus.done, 1);
      chk("latency", lat, (dvz || eovf) ? 3 : 2 * N + 3);
      chk("err_dvz", bus.err_dvz, dvz);
      chk("err_ovf", bus.err_ovf, eovf);
      if (!dvz && !eovf) begin
         chk("shifts", cp1_cnt - cp0, N);
         if (!big) begin
            chk("quo", q, int'(a) / int'(dv));
            chk("rem", ah, int'(a) % int'(dv));
            chk("qp1", qp1_cnt - qp0, $countones(int'(a) / int'(dv)));
         end
      end else chk("shifts", cp1_cnt - cp0, 0);
      @(posedge clk);
      #1 chk("done_pulses", done_cnt - dn0, 1);
      chk("ready_after", bus.ready, 1);
      chk("err_dvz_hold", bus.err_dvz, dvz);
   endtask
   initial begin
      int dn0, lat;
      logic [N-1:0] rd;
      rst_n = 1'b0;
      bus.start = 1'b1;
      ain = '0;
      din = '0;
      #3;
      chk("rst_ready", bus.ready, 1);
      chk("rst_done", bus.done, 0);
      chk("rst_errs", {bus.err_dvz, bus.err_ovf}, 0);
      chk("rst_ctrl", {bus.Qp1, bus.Qsl, bus.Qrd, bus.Asl, bus.Ard, bus.Drd, bus.Crst, bus.Cp1, bus.Anew}, 0);
      bus.start = 1'b0;
      #19 rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_op(100, 7, 1'b0);
      run_op(35, 0, 1'b0);
      run_op(300, 7, 1'b0);
      run_op(100, 7, 1'b1);
      ain = 100;
      din = 7;
      bus.start = 1'b1;
      dn0 = done_cnt;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (6) @(posedge clk);
      #1 chk("third_shift", bus.Cp1, 1);
      rst_n = 1'b0;
      #1 chk("async_ready", bus.ready, 1);
      chk("async_ctrl", bus.Cp1, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk("no_done_rst", done_cnt - dn0, 0);
      run_op(63, 8, 1'b0);
      ain = 100;
      din = 7;
      bus.start = 1'b1;
      lat = 0;
      while (!bus.done && lat < 64) begin
         @(posedge clk);
         #1 lat++;
      end
      chk("held_done1", bus.done, 1);
      @(posedge clk);
      #1 chk("held_idle", bus.ready, 1);
      @(posedge clk);
      #1 chk("held_restart", bus.ready, 0);
      bus.start = 1'b0;
      lat = 0;
      while (!bus.done && lat < 64) begin
         @(posedge clk);
         #1 lat++;
      end
      chk("held_done2", bus.done, 1);
      chk("held_quo", q, 14);
      @(posedge clk);
      #1;
      for (int i = 0; i < 24; i++) begin
         rd = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom_range(1, (1 << N) - 1));
         if (i % 2 == 1 && rd != 0)
            run_op((2*N)'(rd * $urandom_range(0, (1 << N) - 1) + $urandom_range(0, rd - 1)), rd, 1'b0);
         else
            run_op((2*N)'($urandom_range(0, (1 << (2 * N)) - 1)), rd, 1'b0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
